// File: rtl/penta_nav_ctrl_if.sv
// Command port of the navigation controller: a registered valid/ready
// channel carrying one slot write (index + value) per handshake.
interface penta_nav_ctrl_if #(
    parameter int CW    = 2,
    parameter int VAL_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CW-1:0]    cmd_slot;
    logic [VAL_W-1:0] cmd_value;

    modport master (
        output cmd_valid,
        output cmd_slot,
        output cmd_value,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_slot,
        input  cmd_value,
        output cmd_ready
    );
endinterface

// File: rtl/penta_nav_ctrl.sv
// Five-button browse/edit/commit controller over a bank of settings slots;
// committed values leave through the valid/ready command interface.
module penta_nav_ctrl #(
    parameter int NUM_SLOTS = 4,
    parameter int VAL_W     = 8,
    parameter int TIMEOUT   = 1000000,
    localparam int CW = ($clog2(NUM_SLOTS) < 1) ? 1 : $clog2(NUM_SLOTS),
    localparam int TW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1)
) (
    input  logic                sysclk,
    input  logic                reset_n,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                btn_ok,
    penta_nav_ctrl_if.master    cmd,
    output logic [1:0]          mode,
    output logic [CW-1:0]       cursor,
    output logic [VAL_W-1:0]    cur_value
);

    typedef enum logic [1:0] {
        ST_BROWSE = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [CW-1:0]    LAST_SLOT = CW'(NUM_SLOTS - 1);
    localparam logic [VAL_W-1:0] MAX_VAL   = '1;
    localparam logic [TW-1:0]    TMO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state_q, state_d;
    logic [CW-1:0]    cursor_q, cursor_d;
    logic [VAL_W-1:0] edit_q, edit_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             valid_q, valid_d;
    logic [VAL_W-1:0] slot_q [NUM_SLOTS];
    logic [VAL_W-1:0] slot_d [NUM_SLOTS];

    // Fixed priority ok > left > right > up > down; losers are dropped.
    logic any_press;
    logic p_ok, p_left, p_right, p_up, p_down;

    always_comb begin
        any_press = btn_ok | btn_left | btn_right | btn_up | btn_down;
        p_ok      = btn_ok;
        p_left    = btn_left  & ~btn_ok;
        p_right   = btn_right & ~btn_ok & ~btn_left;
        p_up      = btn_up    & ~btn_ok & ~btn_left & ~btn_right;
        p_down    = btn_down  & ~btn_ok & ~btn_left & ~btn_right & ~btn_up;
    end

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        edit_d   = edit_q;
        tmo_d    = tmo_q;
        valid_d  = valid_q;
        slot_d   = slot_q;

        case (state_q)
            ST_BROWSE: begin
                tmo_d = '0;
                if (p_ok) begin
                    edit_d  = slot_q[cursor_q];
                    state_d = ST_EDIT;
                end else if (p_left) begin
                    cursor_d = (cursor_q == '0) ? LAST_SLOT : cursor_q - CW'(1);
                end else if (p_right) begin
                    cursor_d = (cursor_q == LAST_SLOT) ? '0 : cursor_q + CW'(1);
                end
            end

            ST_EDIT: begin
                if (p_ok) begin
                    state_d = ST_COMMIT;
                    valid_d = 1'b1;
                    tmo_d   = '0;
                end else if (p_left) begin
                    state_d = ST_BROWSE;
                    tmo_d   = '0;
                end else if (any_press) begin
                    // Every press, even a dropped or ignored one, restarts the idle count.
                    tmo_d = '0;
                    if (p_up && edit_q != MAX_VAL) begin
                        edit_d = edit_q + VAL_W'(1);
                    end else if (p_down && edit_q != '0) begin
                        edit_d = edit_q - VAL_W'(1);
                    end
                end else if (TIMEOUT > 0) begin
                    if (tmo_q == TMO_LAST) begin
                        state_d = ST_BROWSE;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end

            ST_COMMIT: begin
                tmo_d = '0;
                if (cmd.cmd_ready) begin
                    slot_d[cursor_q] = edit_q;
                    state_d          = ST_BROWSE;
                    valid_d          = 1'b0;
                end
            end

            default: begin
                state_d = ST_BROWSE;
                valid_d = 1'b0;
                tmo_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            state_q  <= ST_BROWSE;
            cursor_q <= '0;
            edit_q   <= '0;
            tmo_q    <= '0;
            valid_q  <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            edit_q   <= edit_d;
            tmo_q    <= tmo_d;
            valid_q  <= valid_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    // Command fields come straight from the frozen cursor/edit registers.
    assign cmd.cmd_valid = valid_q;
    assign cmd.cmd_slot  = cursor_q;
    assign cmd.cmd_value = edit_q;

    assign mode      = state_q;
    assign cursor    = cursor_q;
    assign cur_value = (state_q == ST_BROWSE) ? slot_q[cursor_q] : edit_q;

endmodule

// File: tb/tb_penta_nav_ctrl.sv
// Scoreboard bench for penta_nav_ctrl: stimulus queues expected observations
// and commands; a negedge monitor pops and compares them.
module tb_penta_nav_ctrl;

    localparam int NUM_SLOTS = 4;
    localparam int VAL_W     = 8;
    localparam int TIMEOUT   = 16;
    localparam int CW        = 2;

    localparam logic [4:0] B_NONE  = 5'b00000;
    localparam logic [4:0] B_OK    = 5'b10000;
    localparam logic [4:0] B_LEFT  = 5'b01000;
    localparam logic [4:0] B_RIGHT = 5'b00100;
    localparam logic [4:0] B_UP    = 5'b00010;
    localparam logic [4:0] B_DOWN  = 5'b00001;

    logic             sysclk;
    logic             reset_n;
    logic             btn_up, btn_down, btn_left, btn_right, btn_ok;
    logic [1:0]       mode;
    logic [CW-1:0]    cursor;
    logic [VAL_W-1:0] cur_value;

    penta_nav_ctrl_if #(.CW(CW), .VAL_W(VAL_W)) cmd_if ();

    penta_nav_ctrl #(
        .NUM_SLOTS (NUM_SLOTS),
        .VAL_W     (VAL_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .sysclk    (sysclk),
        .reset_n   (reset_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_ok    (btn_ok),
        .cmd       (cmd_if),
        .mode      (mode),
        .cursor    (cursor),
        .cur_value (cur_value)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    typedef struct {
        string            name;
        logic [1:0]       mode;
        logic [CW-1:0]    cursor;
        logic [VAL_W-1:0] value;
        logic             valid;
    } st_exp_t;

    typedef struct {
        logic [CW-1:0]    slot;
        logic [VAL_W-1:0] value;
    } cmd_exp_t;

    st_exp_t  st_q[$];
    cmd_exp_t cmd_q[$];
    st_exp_t  mon_e;
    cmd_exp_t mon_c;
    int       n_cmp = 0;
    int       n_bad = 0;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // One clock with the given pulses, order {ok,left,right,up,down}.
    task automatic press(input logic [4:0] b);
        {btn_ok, btn_left, btn_right, btn_up, btn_down} = b;
        tick();
        {btn_ok, btn_left, btn_right, btn_up, btn_down} = B_NONE;
    endtask

    task automatic chk(input string nm, input logic [1:0] m, input logic [CW-1:0] c,
                       input logic [VAL_W-1:0] v, input logic vld);
        st_exp_t e;
        e.name   = nm;
        e.mode   = m;
        e.cursor = c;
        e.value  = v;
        e.valid  = vld;
        st_q.push_back(e);
    endtask

    task automatic exp_cmd(input logic [CW-1:0] s, input logic [VAL_W-1:0] v);
        cmd_exp_t c;
        c.slot  = s;
        c.value = v;
        cmd_q.push_back(c);
    endtask

    // Monitor: observation checks plus handshake scoreboard.
    always @(negedge sysclk) begin
        while (st_q.size() > 0) begin
            mon_e = st_q.pop_front();
            n_cmp++;
            if (mode !== mon_e.mode || cursor !== mon_e.cursor || cur_value !== mon_e.value ||
                cmd_if.cmd_valid !== mon_e.valid ||
                (mon_e.valid && (cmd_if.cmd_slot !== mon_e.cursor || cmd_if.cmd_value !== mon_e.value))) begin
                n_bad++;
                $display("FAIL %s: got mode=%0d cursor=%0d value=%0d valid=%0d slot=%0d cmdval=%0d; expected mode=%0d cursor=%0d value=%0d valid=%0d",
                         mon_e.name, mode, cursor, cur_value, cmd_if.cmd_valid, cmd_if.cmd_slot,
                         cmd_if.cmd_value, mon_e.mode, mon_e.cursor, mon_e.value, mon_e.valid);
            end
        end
        if (reset_n && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
            n_cmp++;
            if (cmd_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_cmd: got slot=%0d value=%0d, expected no command",
                         cmd_if.cmd_slot, cmd_if.cmd_value);
            end else begin
                mon_c = cmd_q.pop_front();
                if (cmd_if.cmd_slot !== mon_c.slot || cmd_if.cmd_value !== mon_c.value) begin
                    n_bad++;
                    $display("FAIL cmd_handshake: got slot=%0d value=%0d, expected slot=%0d value=%0d",
                             cmd_if.cmd_slot, cmd_if.cmd_value, mon_c.slot, mon_c.value);
                end else begin
                    $display("cmd handshake slot=%0d value=%0d", cmd_if.cmd_slot, cmd_if.cmd_value);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of stimulus, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n          = 1'b0;
        cmd_if.cmd_ready = 1'b0;
        {btn_ok, btn_left, btn_right, btn_up, btn_down} = B_NONE;

        // Reset and idle
        repeat (3) tick();
        chk("in_reset", 2'd0, 2'd0, 8'd0, 1'b0);
        reset_n = 1'b1;
        tick();
        chk("after_reset", 2'd0, 2'd0, 8'd0, 1'b0);
        cmd_if.cmd_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            press(B_NONE);
            chk("idle", 2'd0, 2'd0, 8'd0, 1'b0);
        end
        cmd_if.cmd_ready = 1'b0;

        // Cursor wrap and ignored up/down in BROWSE
        press(B_LEFT);   chk("wrap_left", 2'd0, 2'd3, 8'd0, 1'b0);
        press(B_RIGHT);  chk("wrap_right", 2'd0, 2'd0, 8'd0, 1'b0);
        press(B_RIGHT);  chk("right", 2'd0, 2'd1, 8'd0, 1'b0);
        press(B_UP);     chk("browse_up", 2'd0, 2'd1, 8'd0, 1'b0);
        press(B_DOWN);   chk("browse_down", 2'd0, 2'd1, 8'd0, 1'b0);

        // Edit slot 2 to 4, hold commit off for four cycles
        press(B_RIGHT);  chk("to_slot2", 2'd0, 2'd2, 8'd0, 1'b0);
        press(B_OK);     chk("enter_edit", 2'd1, 2'd2, 8'd0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            press(B_UP);
            chk("edit_up", 2'd1, 2'd2, 8'(i), 1'b0);
        end
        press(B_DOWN);   chk("edit_down", 2'd1, 2'd2, 8'd4, 1'b0);
        exp_cmd(2'd2, 8'd4);
        press(B_OK);     chk("commit_c1", 2'd2, 2'd2, 8'd4, 1'b1);
        press(B_UP);     chk("commit_c2", 2'd2, 2'd2, 8'd4, 1'b1);
        press(B_LEFT);   chk("commit_c3", 2'd2, 2'd2, 8'd4, 1'b1);
        press(B_OK);     chk("commit_c4", 2'd2, 2'd2, 8'd4, 1'b1);
        press(B_DOWN);   chk("commit_c5", 2'd2, 2'd2, 8'd4, 1'b1);
        cmd_if.cmd_ready = 1'b1;
        press(B_RIGHT);  chk("after_handshake", 2'd0, 2'd2, 8'd4, 1'b0);
        cmd_if.cmd_ready = 1'b0;

        // Saturation at 0 and at 255, priority ok over up
        press(B_LEFT);   chk("to_slot1", 2'd0, 2'd1, 8'd0, 1'b0);
        press(B_LEFT);   chk("to_slot0", 2'd0, 2'd0, 8'd0, 1'b0);
        press(B_OK);     chk("edit_slot0", 2'd1, 2'd0, 8'd0, 1'b0);
        press(B_DOWN);   chk("sat_low", 2'd1, 2'd0, 8'd0, 1'b0);
        for (int i = 0; i < 255; i++) press(B_UP);
        chk("reach_max", 2'd1, 2'd0, 8'd255, 1'b0);
        press(B_UP);     chk("sat_high", 2'd1, 2'd0, 8'd255, 1'b0);
        exp_cmd(2'd0, 8'd255);
        press(B_OK | B_UP); chk("ok_beats_up", 2'd2, 2'd0, 8'd255, 1'b1);
        cmd_if.cmd_ready = 1'b1;
        press(B_NONE);   chk("slot0_written", 2'd0, 2'd0, 8'd255, 1'b0);
        press(B_OK);     chk("reload_255", 2'd1, 2'd0, 8'd255, 1'b0);
        press(B_UP);     chk("sat_high_reload", 2'd1, 2'd0, 8'd255, 1'b0);
        press(B_LEFT);   chk("cancel_slot0", 2'd0, 2'd0, 8'd255, 1'b0);

        // Cancel after edits leaves the slot alone
        press(B_RIGHT);  chk("to_slot1b", 2'd0, 2'd1, 8'd0, 1'b0);
        press(B_OK);     chk("edit_slot1", 2'd1, 2'd1, 8'd0, 1'b0);
        repeat (3) press(B_UP);
        chk("edit_up3", 2'd1, 2'd1, 8'd3, 1'b0);
        press(B_LEFT);   chk("cancel", 2'd0, 2'd1, 8'd0, 1'b0);

        // Timeout: back to BROWSE exactly 16 cycles after entry
        press(B_OK);     chk("tmo_entry", 2'd1, 2'd1, 8'd0, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            press(B_NONE);
            chk("tmo_wait", 2'd1, 2'd1, 8'd0, 1'b0);
        end
        press(B_NONE);   chk("tmo_expire", 2'd0, 2'd1, 8'd0, 1'b0);

        // Right press at cycle 10 restarts the count
        press(B_OK);     chk("tmo2_entry", 2'd1, 2'd1, 8'd0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            press(B_NONE);
            chk("tmo2_wait_a", 2'd1, 2'd1, 8'd0, 1'b0);
        end
        press(B_RIGHT);  chk("tmo2_right", 2'd1, 2'd1, 8'd0, 1'b0);
        for (int i = 11; i <= 25; i++) begin
            press(B_NONE);
            chk("tmo2_wait_b", 2'd1, 2'd1, 8'd0, 1'b0);
        end
        press(B_NONE);   chk("tmo2_expire", 2'd0, 2'd1, 8'd0, 1'b0);

        // Reset while a command is pending
        cmd_if.cmd_ready = 1'b0;
        press(B_OK);     chk("rst_edit", 2'd1, 2'd1, 8'd0, 1'b0);
        press(B_UP);     chk("rst_up", 2'd1, 2'd1, 8'd1, 1'b0);
        press(B_OK);     chk("rst_commit", 2'd2, 2'd1, 8'd1, 1'b1);
        press(B_NONE);   chk("rst_hold", 2'd2, 2'd1, 8'd1, 1'b1);
        reset_n = 1'b0;
        tick();
        chk("rst_mid_commit", 2'd0, 2'd0, 8'd0, 1'b0);
        reset_n = 1'b1;
        cmd_if.cmd_ready = 1'b1;
        press(B_NONE);   chk("rst_slot0", 2'd0, 2'd0, 8'd0, 1'b0);
        press(B_RIGHT);  chk("rst_slot1", 2'd0, 2'd1, 8'd0, 1'b0);
        press(B_RIGHT);  chk("rst_slot2", 2'd0, 2'd2, 8'd0, 1'b0);
        press(B_RIGHT);  chk("rst_slot3", 2'd0, 2'd3, 8'd0, 1'b0);

        @(negedge sysclk);
        #1;
        n_cmp++;
        if (cmd_q.size() != 0) begin
            n_bad++;
            $display("FAIL cmd_drain: got %0d outstanding commands, expected 0", cmd_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
